resp_compactor: RTL and testbench
=================================

RESP_COMPACTOR -- requirements
Module: resp_compactor

Interface
REQ-001 SHALL have parameter WIDTH, default 3: response bits per vector, i.e. the netlist-under-test primary outputs, e.g. n11..n13.
REQ-002 SHALL have parameter SIG_W, default 16: signature register width; legal range SIG_W > WIDTH.
REQ-003 SHALL have parameter CNT_W, default 8: vector-count width.
REQ-004 SHALL have parameter POLY, default 16'h1021: MISR feedback polynomial, SIG_W bits.
REQ-005 SHALL have parameter SEED, default 0: signature initial value, SIG_W bits.
REQ-006 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: begin a compaction run.
REQ-009 SHALL have port num_vec, input, CNT_W: vectors in the run; sampled at start.
REQ-010 SHALL have port in_valid, input, 1: response beat present.
REQ-011 SHALL have port in_ready, output, 1: compactor accepts the beat.
REQ-012 SHALL have port resp, input, WIDTH: response vector from the netlist outputs.
REQ-013 SHALL have port golden, input, SIG_W: expected signature; sampled at start.
REQ-014 SHALL have port busy, output, 1: run in progress.
REQ-015 SHALL have port done, output, 1: run complete; signature final.
REQ-016 SHALL have port signature, output, SIG_W: current MISR contents.
REQ-017 SHALL have port pass, output, 1: signature == golden; meaningful only while done=1.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 In IDLE or DONE, start=1 SHALL load signature<=SEED, remaining<=num_vec, golden_q<=golden, and clear done. It SHALL go to RUN if num_vec!=0, else to DONE.
REQ-020 RUN SHALL drive in_ready=1 and busy=1. IDLE and DONE SHALL drive in_ready=0 and busy=0.
REQ-021 Beat accepted = in_valid & in_ready. There is no accept when in_valid=0; there are no stall cycles and no combinational path from in_valid to in_ready.
REQ-022 On each accept, the MISR update SHALL be signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(resp). This is modulo 2^SIG_W, one update per accept.
REQ-023 On each accept, remaining SHALL decrement by 1. An accept with remaining==1 SHALL transition to DONE on the same edge.
REQ-024 DONE SHALL hold done=1 and a frozen signature until the next start. pass SHALL be registered from the final signature vs golden_q and valid in the first DONE cycle.
REQ-025 start while in RUN SHALL be ignored. The run continues unchanged.
REQ-026 in_valid in IDLE or DONE SHALL be ignored, with no signature change.
REQ-027 Accept latency SHALL be 1 cycle: the signature reflects a beat on the edge after it is accepted.
REQ-028 With num_vec==2^CNT_W-1, exactly that many beats SHALL be accepted. The counter SHALL NOT wrap.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, signature=SEED, remaining=0, golden_q=0, done=0, pass=0, busy=0, in_ready=0.
REQ-030 Reset asserted mid-RUN SHALL abort the run. After release, the block SHALL wait in IDLE for a new start, with no partial result retained.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the default POLY/SEED constants. The timing-benchmark harness reuses them.
REQ-032 The MISR next-state function SHALL be a combinational sub-module misr_step (inputs sig, resp; output next_sig). FSM and counter SHALL stay in resp_compactor.
REQ-033 Estimated size is 150-250 RTL lines total.

Verification (defaults SIG_W=16, POLY=16'h1021, SEED=0 unless stated)
REQ-034 Single vector: start with num_vec=1 and golden=16'h0005, then one beat resp=3'b101. Required: signature=16'h0005, done=1, pass=1, in_ready=0 next cycle.
REQ-035 Two vectors with a gap: num_vec=2; beats resp=5, then in_valid=0 for 3 cycles, then resp=3. Required: signature 0x0005 then 0x0009, done only after the second beat.
REQ-036 Feedback: SEED=16'h8000, num_vec=1, resp=0. Required: signature=16'h1021. golden=16'h1020 gives pass=0.
REQ-037 Zero count: start with num_vec=0. Required: DONE on the next cycle, in_ready never 1, signature=SEED.
REQ-038 Reset mid-run: num_vec=4, rst pulsed after 2 beats. Required: IDLE, signature=SEED, done=0. A later start with num_vec=1 and resp=5 gives 0x0005.
REQ-039 start held high during RUN: num_vec=3. Required: exactly 3 beats accepted, remaining unaffected by start.

Source files
------------

// File: rtl/resp_compactor_pkg.sv
// Shared types and default constants for the response compactor and its timing harness.
package resp_compactor_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [15:0] DefPoly = 16'h1021;
   localparam logic [15:0] DefSeed = 16'h0000;

endpackage

// File: rtl/resp_compactor_misr_step.sv
// One MISR step: shift with polynomial feedback, then fold in the zero-extended response.
module misr_step #(
   parameter int unsigned     WIDTH = 3,
   parameter int unsigned     SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
   input  logic [SIG_W-1:0] sig,
   input  logic [WIDTH-1:0] resp,
   output logic [SIG_W-1:0] next_sig
);

   logic [SIG_W-1:0] feedback;
   logic [SIG_W-1:0] resp_ext;

   always_comb begin
      feedback = sig[SIG_W-1] ? POLY : '0;
      resp_ext = {{(SIG_W-WIDTH){1'b0}}, resp};
      next_sig = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ resp_ext;
   end

endmodule

// File: rtl/resp_compactor.sv
// Response compactor: folds a counted run of response beats into a MISR signature and
// compares the final value against a golden signature captured at start.
module resp_compactor
   import resp_compactor_pkg::*;
#(
   parameter int unsigned      WIDTH = 3,
   parameter int unsigned      SIG_W = 16,
   parameter int unsigned      CNT_W = 8,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefPoly),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(DefSeed)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] resp,
   input  logic [SIG_W-1:0] golden,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic             pass
);

   state_e           state_q, state_d;
   logic [SIG_W-1:0] sig_q, next_sig;
   logic [CNT_W-1:0] remaining_q;
   logic [SIG_W-1:0] golden_q;
   logic             pass_q;
   logic             start_ok, accept, last;

   misr_step #(
      .WIDTH(WIDTH),
      .SIG_W(SIG_W),
      .POLY (POLY)
   ) u_misr_step (
      .sig     (sig_q),
      .resp    (resp),
      .next_sig(next_sig)
   );

   // in_ready depends only on state, so accept never loops back through in_valid.
   assign start_ok = start & (state_q != StRun);
   assign accept   = in_valid & in_ready;
   assign last     = (remaining_q == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) state_d = (num_vec != '0) ? StRun : StDone;
         end
         StRun: begin
            if (accept && last) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StRun: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q       <= SEED;
         remaining_q <= '0;
         golden_q    <= '0;
         pass_q      <= 1'b0;
      end else if (start_ok) begin
         sig_q       <= SEED;
         remaining_q <= num_vec;
         golden_q    <= golden;
         // A zero-length run is final immediately, so its verdict is the seed itself.
         pass_q      <= (num_vec == '0) && (SEED == golden);
      end else if (accept) begin
         sig_q       <= next_sig;
         remaining_q <= remaining_q - CNT_W'(1);
         if (last) pass_q <= (next_sig == golden_q);
      end
   end

   assign signature = sig_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_resp_compactor.sv
// Randomized bench for resp_compactor: two instances (seed 0 and seed 0x8000) share stimulus
// and are compared every cycle against a behavioural model of the compaction run.
module tb_resp_compactor;

   localparam logic [15:0] Seed0 = 16'h0000;
   localparam logic [15:0] Seed1 = 16'h8000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_vec = '0;
   logic        in_valid = 1'b0;
   logic [2:0]  resp = '0;
   logic [15:0] golden = '0;

   logic        in_ready0, busy0, done0, pass0;
   logic        in_ready1, busy1, done1, pass1;
   logic [15:0] sig0, sig1;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   bit          m_run, m_done;
   int          m_rem;
   logic [15:0] m_gold;
   logic [15:0] m_sig0, m_sig1;
   bit          m_pass0, m_pass1;

   always #5 clk = ~clk;

   resp_compactor #(.SEED(Seed0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_valid(in_valid),
      .in_ready(in_ready0), .resp(resp), .golden(golden), .busy(busy0), .done(done0),
      .signature(sig0), .pass(pass0)
   );

   resp_compactor #(.SEED(Seed1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_valid(in_valid),
      .in_ready(in_ready1), .resp(resp), .golden(golden), .busy(busy1), .done(done1),
      .signature(sig1), .pass(pass1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Signature as a polynomial over GF(2): multiply by x mod 2^16, reduce, add response.
   function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [2:0] r);
      int unsigned v;
      v = 32'(s) * 2;
      if (v >= 65536) v = (v - 65536) ^ 32'h1021;
      return 16'(v ^ 32'(r));
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_rem = 0; m_gold = '0;
      m_sig0 = Seed0; m_sig1 = Seed1; m_pass0 = 0; m_pass1 = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_ready0"}, 32'(in_ready0), 32'(m_run));
      check({tag, "_ready1"}, 32'(in_ready1), 32'(m_run));
      check({tag, "_busy0"}, 32'(busy0), 32'(m_run));
      check({tag, "_done0"}, 32'(done0), 32'(m_done));
      check({tag, "_done1"}, 32'(done1), 32'(m_done));
      check({tag, "_sig0"}, 32'(sig0), 32'(m_sig0));
      check({tag, "_sig1"}, 32'(sig1), 32'(m_sig1));
      if (m_done) begin
         check({tag, "_pass0"}, 32'(pass0), 32'(m_pass0));
         check({tag, "_pass1"}, 32'(pass1), 32'(m_pass1));
      end
   endtask

   // Advance the model with the inputs the DUT is about to sample, clock, then compare.
   task automatic tick(input string tag);
      if (!m_run && start) begin
         m_sig0 = Seed0; m_sig1 = Seed1; m_rem = int'(num_vec); m_gold = golden;
         m_run  = (num_vec != 0);
         m_done = (num_vec == 0);
         m_pass0 = (Seed0 == golden);
         m_pass1 = (Seed1 == golden);
      end else if (m_run && in_valid) begin
         m_sig0 = model_misr(m_sig0, resp);
         m_sig1 = model_misr(m_sig1, resp);
         m_rem--;
         if (m_rem == 0) begin
            m_run = 0; m_done = 1;
            m_pass0 = (m_sig0 == m_gold);
            m_pass1 = (m_sig1 == m_gold);
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic quiet();
      start = 0; in_valid = 0; resp = '0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1;
      #2;
      model_reset();
      check_all(tag);
      check({tag, "_pass0"}, 32'(pass0), 32'd0);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic begin_run(input string tag, input int n, input logic [15:0] g);
      start = 1; num_vec = 8'(n); golden = g; in_valid = 0;
      tick(tag);
      start = 0;
   endtask

   task automatic beat(input string tag, input logic [2:0] r);
      in_valid = 1; resp = r;
      tick(tag);
      quiet();
   endtask

   initial begin
      int accepted;
      model_reset();
      #1;
      do_reset("reset");

      // Single vector with matching golden
      begin_run("single_start", 1, 16'h0005);
      beat("single_beat", 3'b101);
      check("single_sig_exact", 32'(sig0), 32'h0005);
      check("single_pass_exact", 32'(pass0), 32'd1);
      tick("single_after");
      check("single_ready_low", 32'(in_ready0), 32'd0);

      // Two vectors with an idle gap
      begin_run("gap_start", 2, 16'h0009);
      beat("gap_b1", 3'd5);
      check("gap_sig1_exact", 32'(sig0), 32'h0005);
      check("gap_notdone", 32'(done0), 32'd0);
      for (int i = 0; i < 3; i++) tick("gap_idle");
      beat("gap_b2", 3'd3);
      check("gap_sig2_exact", 32'(sig0), 32'h0009);
      check("gap_done", 32'(done0), 32'd1);

      // Feedback path on the 0x8000-seeded instance
      begin_run("fb_start", 1, 16'h1020);
      beat("fb_beat", 3'd0);
      check("fb_sig_exact", 32'(sig1), 32'h1021);
      check("fb_pass_exact", 32'(pass1), 32'd0);

      // Beats outside a run are ignored
      for (int i = 0; i < 3; i++) beat("done_ignore", 3'($urandom));

      // Zero-length run
      begin_run("zero_start", 0, 16'h8000);
      check("zero_done", 32'(done0), 32'd1);
      check("zero_sig1", 32'(sig1), 32'h8000);
      for (int i = 0; i < 2; i++) beat("zero_beat", 3'd7);

      // Reset in the middle of a run
      begin_run("rst_start", 4, 16'h0);
      beat("rst_b1", 3'd1);
      beat("rst_b2", 3'd2);
      do_reset("rst_mid");
      check("rst_done", 32'(done0), 32'd0);
      for (int i = 0; i < 2; i++) beat("rst_idle_beat", 3'd6);
      begin_run("rst_restart", 1, 16'h0005);
      beat("rst_b", 3'd5);
      check("rst_sig_exact", 32'(sig0), 32'h0005);

      // start held high throughout a run
      start = 1; num_vec = 8'd3; golden = 16'h0003; in_valid = 0;
      tick("hold_start");
      for (int i = 1; i <= 3; i++) begin
         start = 1; in_valid = 1; resp = 3'(i); num_vec = 8'd7;
         tick("hold_beat");
      end
      quiet();
      check("hold_sig_exact", 32'(sig0), 32'h0003);
      check("hold_done", 32'(done0), 32'd1);
      check("hold_pass", 32'(pass0), 32'd1);

      // Maximum count: exactly 255 accepts, no wrap
      begin_run("max_start", 255, 16'h1234);
      accepted = 0;
      for (int i = 0; i < 1000 && !m_done; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         resp = 3'($urandom);
         if (in_valid && in_ready0) accepted++;
         tick("max_run");
      end
      quiet();
      check("max_accepted", 32'(accepted), 32'd255);
      check("max_done", 32'(done0), 32'd1);

      // Random runs including spurious starts mid-run
      for (int i = 0; i < 400; i++) begin
         start   = ($urandom_range(0, 7) == 0);
         num_vec = 8'($urandom_range(0, 6));
         golden  = ($urandom_range(0, 3) == 0) ? m_sig0 : 16'($urandom);
         in_valid = ($urandom_range(0, 2) != 0);
         resp    = 3'($urandom);
         tick("rand");
      end
      quiet();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
